// File: rtl/bmd_256_timestamp_drain.sv
// Drains the RX timestamp FIFO into 256-bit AXI-Stream beats, one sample per 32-bit lane.
// Optional macro BMD_TS_DELTA_EN: emit successive differences instead of raw samples.
module bmd_256_timestamp_drain #(
  parameter int TS_W  = 30,
  parameter int LANES = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  latency_reset_signal,
  input  logic                  fifo_read_trigger,
  input  logic                  fifo_empty,
  input  logic [TS_W-1:0]       fifo_dout,
  output logic                  fifo_rd_en,
  output logic [LANES*32-1:0]   m_tdata,
  output logic [LANES-1:0]      m_tkeep,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic [CNT_W-1:0]      beat_count,
  output logic                  drain_done
);

  localparam int LC_W = $clog2(LANES + 1);

  typedef enum logic [1:0] {IDLE, FILL, SEND, DONE} state_t;

  state_t            state_reg, state_next;
  logic              clr;
  logic [LC_W-1:0]   lane_cnt_reg;
  logic [LC_W-1:0]   req_cnt_reg;
  logic              rd_pend_reg;
  logic              last_reg;
  logic [CNT_W-1:0]  beat_count_reg;
  logic              drain_done_reg;
  logic              pop;
  logic              handshake;
  logic [TS_W-1:0]   cap_val;

  // Soft clear behaves exactly like the hard reset.
  assign clr = !rst_n || latency_reset_signal;

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fifo_read_trigger && !fifo_empty) state_next = FILL;
      end
      FILL: begin
        pop = !fifo_empty && (req_cnt_reg < LC_W'(LANES));
        if (lane_cnt_reg == LC_W'(LANES)) begin
          state_next = SEND;
        end else if (fifo_empty && (req_cnt_reg == lane_cnt_reg)) begin
          state_next = (lane_cnt_reg != '0) ? SEND : DONE;
        end
      end
      SEND: begin
        if (m_tready) state_next = last_reg ? DONE : FILL;
      end
      DONE: begin
        if (!fifo_read_trigger) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (clr) pop = 1'b0;
  end

  assign handshake  = (state_reg == SEND) && m_tready && !clr;
  assign fifo_rd_en = pop;
  assign m_tvalid   = (state_reg == SEND) && !clr;
  assign m_tlast    = m_tvalid && last_reg;
  assign beat_count = beat_count_reg;
  assign drain_done = drain_done_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg      <= IDLE;
      lane_cnt_reg   <= '0;
      req_cnt_reg    <= '0;
      rd_pend_reg    <= 1'b0;
      last_reg       <= 1'b0;
      beat_count_reg <= '0;
      drain_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rd_pend_reg    <= pop;
      drain_done_reg <= (state_next == DONE) && (state_reg != DONE);
      // tlast is frozen at SEND entry so it cannot move while the beat waits for tready.
      if (state_reg == FILL && state_next == SEND) last_reg <= fifo_empty;
      if (handshake) begin
        lane_cnt_reg <= '0;
        req_cnt_reg  <= '0;
        if (beat_count_reg != '1) beat_count_reg <= beat_count_reg + 1'b1;
      end else begin
        if (rd_pend_reg) lane_cnt_reg <= lane_cnt_reg + 1'b1;
        if (pop)         req_cnt_reg  <= req_cnt_reg + 1'b1;
      end
    end
  end

`ifdef BMD_TS_DELTA_EN
  logic [TS_W-1:0] prev_ts_reg;

  // prev_ts is zero at burst start, so the first sample passes through raw.
  assign cap_val = fifo_dout - prev_ts_reg;

  always_ff @(posedge clk) begin
    if (clr || state_reg == IDLE) begin
      prev_ts_reg <= '0;
    end else if (rd_pend_reg) begin
      prev_ts_reg <= fifo_dout;
    end
  end
`else
  assign cap_val = fifo_dout;
`endif

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : gen_lane
      logic [TS_W-1:0] lane_reg;
      logic            keep_reg;

      always_ff @(posedge clk) begin
        if (clr || handshake) begin
          lane_reg <= '0;
          keep_reg <= 1'b0;
        end else if (rd_pend_reg && lane_cnt_reg == LC_W'(gi)) begin
          lane_reg <= cap_val;
          keep_reg <= 1'b1;
        end
      end

      assign m_tdata[32*gi +: 32] = 32'(lane_reg);
      assign m_tkeep[gi]          = keep_reg;
    end
  endgenerate

endmodule
